// File: rtl/comparator_operand_loader.sv
// Serial operand loader and result capture stage for comparator_3bit.
// Shifts A then B in MSB first, presents them to the comparator, samples its
// outputs for one cycle, and holds the registered result until acknowledged.
module comparator_operand_loader #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             equal,
  input  logic             A_greater,
  input  logic             B_greater,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_equal,
  output logic             res_A_greater,
  output logic             res_B_greater,
  output logic             res_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          take;
  logic          last_bit;
  logic [1:0]    hot_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    ser_ready = 1'b0;
    res_valid = 1'b0;
    take      = 1'b0;
    last_bit  = 1'b0;
    case (state)
      LOAD_A: begin
        ser_ready = 1'b1;
        take      = ser_valid;
        last_bit  = take && (cnt == LAST);
        if (last_bit) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        ser_ready = 1'b1;
        take      = ser_valid;
        last_bit  = take && (cnt == LAST);
        if (last_bit) state_nxt = SAMPLE;
      end
      SAMPLE: state_nxt = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // Number of asserted comparator outputs; exactly one is the healthy case
  always_comb begin
    hot_sum = {1'b0, equal} + {1'b0, A_greater} + {1'b0, B_greater};
  end

  // Bit counter, operand shift registers and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      A             <= '0;
      B             <= '0;
      res_equal     <= 1'b0;
      res_A_greater <= 1'b0;
      res_B_greater <= 1'b0;
      res_err       <= 1'b0;
    end else begin
      if (take) begin
        cnt <= last_bit ? '0 : cnt + CW'(1);
        if (state == LOAD_A) A <= {A[WIDTH-2:0], ser_in};
        else                 B <= {B[WIDTH-2:0], ser_in};
      end
      if (state == SAMPLE) begin
        res_equal     <= equal;
        res_A_greater <= A_greater;
        res_B_greater <= B_greater;
        res_err       <= (hot_sum != 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_comparator_operand_loader.sv
// Bench for comparator_operand_loader with a behavioural comparator that can
// be overridden to inject faulty outputs.
module tb_comparator_operand_loader;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_ready;
  logic [W-1:0] A, B;
  logic         equal, A_greater, B_greater;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_equal, res_A_greater, res_B_greater, res_err;

  logic         fault_en = 1'b0;
  logic [2:0]   fault_val = 3'b000;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Comparator in the environment: {equal, A_greater, B_greater}
  assign {equal, A_greater, B_greater} =
    fault_en ? fault_val : {A == B, A > B, A < B};

  comparator_operand_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .A(A), .B(B), .equal(equal),
    .A_greater(A_greater), .B_greater(B_greater), .res_valid(res_valid),
    .res_ready(res_ready), .res_equal(res_equal),
    .res_A_greater(res_A_greater), .res_B_greater(res_B_greater),
    .res_err(res_err)
  );

  // Expected {equal, A_greater, B_greater, err} for healthy comparator
  function automatic logic [3:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ia, ib;
    ia = a; ib = b;
    return {ia == ib, ia > ib, ia < ib, 1'b0};
  endfunction

  // Drives one transaction and reports what was observed; callers compare.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit gapped, input int stall, input bit b2b,
                         output int lat, output int idles, output logic [3:0] res,
                         output logic [W-1:0] oa, output logic [W-1:0] ob,
                         output int stall_bad, output logic ack_valid,
                         output logic ack_ready);
    logic [2*W-1:0] s;
    int k, edge_n;
    s = {a, b};
    k = 0; edge_n = 0; lat = -1; idles = 0; stall_bad = 0;
    res_ready = (stall == 0);
    while (lat < 0 && edge_n < 200) begin
      if (k < 2*W) begin
        ser_valid = !(gapped && (edge_n % 2 == 1));
        ser_in    = s[2*W-1-k];
      end else begin
        ser_valid = b2b;
        ser_in    = 1'b1;
      end
      @(posedge clk); #1;
      edge_n++;
      if (k < 2*W) begin
        if (ser_valid) k++;
        else idles++;
      end
      if (res_valid) lat = edge_n;
    end
    res = {res_equal, res_A_greater, res_B_greater, res_err};
    oa = A; ob = B;
    for (int i = 0; i < stall; i++) begin
      ser_valid = b2b; ser_in = 1'b1;
      @(posedge clk); #1;
      if (!res_valid || ser_ready ||
          {res_equal, res_A_greater, res_B_greater, res_err} != res ||
          A != oa || B != ob)
        stall_bad++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    ack_valid = res_valid;
    ack_ready = ser_ready;
    res_ready = 1'b0;
    ser_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; ser_valid = 1'b0;
    tests++;
    if ({A, B, res_valid, ser_ready, res_equal, res_A_greater, res_B_greater, res_err}
        !== {{2*W{1'b0}}, 1'b0, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL reset: A=%b B=%b rv=%b rdy=%b res=%b%b%b%b (want A=B=0 rv=0 rdy=1 res=0)",
               A, B, res_valid, ser_ready, res_equal, res_A_greater, res_B_greater, res_err);
    end
  endtask

  task automatic test_basic();
    int lat, idl, sb; logic [3:0] r; logic [W-1:0] oa, ob; logic av, ar;
    run_txn(3'b001, 3'b010, 1'b0, 0, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
    tests++;
    if (oa !== 3'b001 || ob !== 3'b010) begin
      fails++; $display("FAIL basic_operands: A=%b B=%b want 001 010", oa, ob);
    end
    tests++;
    if (lat !== 2*W+1) begin
      fails++; $display("FAIL basic_latency: got %0d want %0d", lat, 2*W+1);
    end
    tests++;
    if (r !== 4'b0010) begin
      fails++; $display("FAIL basic_result: got %b want 0010", r);
    end
    tests++;
    if (av !== 1'b0 || ar !== 1'b1) begin
      fails++; $display("FAIL basic_one_cycle: rv=%b rdy=%b after ack, want 0 1", av, ar);
    end
  endtask

  task automatic test_back_to_back();
    int lat, idl, sb; logic [3:0] r; logic [W-1:0] oa, ob; logic av, ar;
    run_txn(3'b101, 3'b110, 1'b0, 3, 1'b1, lat, idl, r, oa, ob, sb, av, ar);
    tests++;
    if (r !== 4'b0010) begin
      fails++; $display("FAIL b2b_first_result: got %b want 0010", r);
    end
    tests++;
    if (sb !== 0) begin
      fails++; $display("FAIL b2b_stall_hold: %0d bad stall cycles, want 0", sb);
    end
    tests++;
    if (av !== 1'b0) begin
      fails++; $display("FAIL b2b_ack: rv=%b want 0", av);
    end
    run_txn(3'b111, 3'b111, 1'b0, 0, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
    tests++;
    if (r !== 4'b1000 || lat !== 2*W+1) begin
      fails++; $display("FAIL b2b_second: res=%b lat=%0d want 1000 lat %0d", r, lat, 2*W+1);
    end
  endtask

  task automatic test_gapped();
    int lat, idl, sb; logic [3:0] r; logic [W-1:0] oa, ob; logic av, ar;
    run_txn(3'b011, 3'b010, 1'b1, 0, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
    tests++;
    if (r !== 4'b0100) begin
      fails++; $display("FAIL gapped_result: got %b want 0100", r);
    end
    tests++;
    if (idl == 0 || lat !== 2*W+1+idl) begin
      fails++; $display("FAIL gapped_latency: got %0d want %0d (idles %0d)", lat, 2*W+1+idl, idl);
    end
  endtask

  task automatic test_mid_reset();
    int lat, idl, sb; logic [3:0] r; logic [W-1:0] oa, ob; logic av, ar;
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_in = 1'b1;
      @(posedge clk);
    end
    #1;
    rst = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ser_valid = 1'b0;
    tests++;
    if (A !== '0 || B !== '0 || ser_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_state: A=%b B=%b rdy=%b rv=%b want 0 0 1 0",
                        A, B, ser_ready, res_valid);
    end
    run_txn(3'b000, 3'b000, 1'b0, 0, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
    tests++;
    if (r !== 4'b1000 || lat !== 2*W+1) begin
      fails++; $display("FAIL midreset_next: res=%b lat=%0d want 1000 lat %0d", r, lat, 2*W+1);
    end
  endtask

  task automatic test_fault();
    int lat, idl, sb; logic [3:0] r, exp; logic [W-1:0] oa, ob; logic av, ar;
    logic [2:0] pats [2];
    pats[0] = 3'b110; pats[1] = 3'b000;
    for (int p = 0; p < 2; p++) begin
      fault_val = pats[p]; fault_en = 1'b1;
      exp = {pats[p], 1'b1};
      run_txn(3'($urandom), 3'($urandom), 1'b0, 0, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
      fault_en = 1'b0;
      tests++;
      if (r !== exp) begin
        fails++; $display("FAIL fault_%0d: got %b want %b", p, r, exp);
      end
    end
  endtask

  task automatic test_random();
    int lat, idl, sb, st; logic [3:0] r, exp; logic [W-1:0] a, b, oa, ob; logic av, ar;
    bit g;
    for (int n = 0; n < 12; n++) begin
      a = W'($urandom); b = W'($urandom);
      if (n % 4 == 0) b = a;
      g = 1'($urandom_range(0, 1)); st = $urandom_range(0, 3);
      exp = model(a, b);
      run_txn(a, b, g, st, 1'b0, lat, idl, r, oa, ob, sb, av, ar);
      tests++;
      if (r !== exp || oa !== a || ob !== b) begin
        fails++; $display("FAIL rand_%0d_result: res=%b A=%b B=%b want %b %b %b",
                          n, r, oa, ob, exp, a, b);
      end
      tests++;
      if (lat !== 2*W+1+idl || sb !== 0 || av !== 1'b0 || ar !== 1'b1) begin
        fails++; $display("FAIL rand_%0d_timing: lat=%0d stallbad=%0d rv=%b rdy=%b want lat %0d 0 0 1",
                          n, lat, sb, av, ar, 2*W+1+idl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_mid_reset();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
